// File: rtl/cpu_pkg.sv
// Shared CPU constants: SM83 register byte/pair indices, inc/dec op encodings
// and flag bit positions within the flag nibble.
package cpu_pkg;

  localparam int unsigned REG_B = 0;
  localparam int unsigned REG_C = 1;
  localparam int unsigned REG_D = 2;
  localparam int unsigned REG_E = 3;
  localparam int unsigned REG_H = 4;
  localparam int unsigned REG_L = 5;
  localparam int unsigned REG_A = 6;
  localparam int unsigned REG_F = 7;

  localparam int unsigned PAIR_BC = 0;
  localparam int unsigned PAIR_DE = 1;
  localparam int unsigned PAIR_HL = 2;
  localparam int unsigned PAIR_AF = 3;

  localparam logic [1:0] IDOP_NONE = 2'b00;
  localparam logic [1:0] IDOP_INC  = 2'b01;
  localparam logic [1:0] IDOP_DEC  = 2'b10;

  // Positions within the {Z,N,H,C} nibble
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_H = 1;
  localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/pair_inc_dec.sv
// Combinational pair increment/decrement, wrapping modulo 2^Width.
// Shared with the SP/PC unit.
module pair_inc_dec
  import cpu_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] value_i,
  input  logic [1:0]       op_i,
  output logic [Width-1:0] result_o
);

  always_comb begin
    result_o = value_i;
    case (op_i)
      IDOP_INC: result_o = value_i + Width'(1);
      IDOP_DEC: result_o = value_i - Width'(1);
      default:  result_o = value_i;
    endcase
  end

endmodule

// File: rtl/cpu_register_file.sv
// SM83-style register file: byte/pair reads, byte/pair writes, pair inc/dec and
// flag nibble writes, with per-byte priority pair > inc/dec > byte > flag.
module cpu_register_file
  import cpu_pkg::*;
#(
  parameter int unsigned                        REG_WIDTH   = 8,
  parameter int unsigned                        NUM_PAIRS   = 4,
  parameter int unsigned                        FLAG_IDX    = 7,
  parameter logic [REG_WIDTH-1:0]               FLAG_MASK   = 8'hF0,
  parameter logic [2*NUM_PAIRS*REG_WIDTH-1:0]   INIT_VALUES = 64'h0013_00D8_014D_01B0,
  localparam int unsigned                       SW          = $clog2(2 * NUM_PAIRS),
  localparam int unsigned                       PW          = $clog2(NUM_PAIRS)
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Enable,
  input  logic [SW-1:0]          i_RdSelA,
  output logic [REG_WIDTH-1:0]   o_RdDataA,
  input  logic [SW-1:0]          i_RdSelB,
  output logic [REG_WIDTH-1:0]   o_RdDataB,
  input  logic [PW-1:0]          i_PairSel,
  output logic [2*REG_WIDTH-1:0] o_PairData,
  input  logic                   i_Write8,
  input  logic [SW-1:0]          i_WrSel8,
  input  logic [REG_WIDTH-1:0]   i_WrData8,
  input  logic                   i_Write16,
  input  logic [PW-1:0]          i_WrPair16,
  input  logic [2*REG_WIDTH-1:0] i_WrData16,
  input  logic [1:0]             i_IdOp,
  input  logic [PW-1:0]          i_IdPair,
  input  logic                   i_FlagWrite,
  input  logic [3:0]             i_FlagData,
  output logic [3:0]             o_Flags
);

  localparam int unsigned NB    = 2 * NUM_PAIRS;
  localparam int unsigned PairW = 2 * REG_WIDTH;

  logic [REG_WIDTH-1:0] regs_q [NB];
  logic [REG_WIDTH-1:0] regs_d [NB];
  logic [PairW-1:0]     id_pair_val;
  logic [PairW-1:0]     id_result;
  logic                 id_active;

  // Reads: combinational, out-of-range selects return zero
  always_comb begin
    o_RdDataA   = '0;
    o_RdDataB   = '0;
    o_PairData  = '0;
    id_pair_val = '0;
    if (32'(i_RdSelA) < NB) o_RdDataA = regs_q[i_RdSelA];
    if (32'(i_RdSelB) < NB) o_RdDataB = regs_q[i_RdSelB];
    if (32'(i_PairSel) < NUM_PAIRS) begin
      o_PairData = {regs_q[{i_PairSel, 1'b0}], regs_q[{i_PairSel, 1'b1}]};
    end
    if (32'(i_IdPair) < NUM_PAIRS) begin
      id_pair_val = {regs_q[{i_IdPair, 1'b0}], regs_q[{i_IdPair, 1'b1}]};
    end
  end

  assign o_Flags   = regs_q[SW'(FLAG_IDX)][REG_WIDTH-1 -: 4];
  assign id_active = (i_IdOp == IDOP_INC) || (i_IdOp == IDOP_DEC);

  pair_inc_dec #(
    .Width (PairW)
  ) u_pair_inc_dec (
    .value_i  (id_pair_val),
    .op_i     (i_IdOp),
    .result_o (id_result)
  );

  // Lowest-priority source first so later assignments override per byte
  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      regs_d[i] = regs_q[i];
      if (i_FlagWrite && (i == FLAG_IDX)) begin
        regs_d[i][REG_WIDTH-1 -: 4] = i_FlagData;
      end
      if (i_Write8 && (32'(i_WrSel8) == i)) begin
        regs_d[i] = i_WrData8;
      end
      if (id_active && (32'(i_IdPair) == i / 2)) begin
        regs_d[i] = (i % 2 == 0) ? id_result[PairW-1 -: REG_WIDTH] : id_result[REG_WIDTH-1:0];
      end
      if (i_Write16 && (32'(i_WrPair16) == i / 2)) begin
        regs_d[i] = (i % 2 == 0) ? i_WrData16[PairW-1 -: REG_WIDTH] : i_WrData16[REG_WIDTH-1:0];
      end
      if (i == FLAG_IDX) begin
        regs_d[i] = regs_d[i] & FLAG_MASK;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int unsigned i = 0; i < NB; i++) begin
        regs_q[i] <= INIT_VALUES[(NB-1-i)*REG_WIDTH +: REG_WIDTH]
                     & ((i == FLAG_IDX) ? FLAG_MASK : {REG_WIDTH{1'b1}});
      end
    end else if (i_Enable) begin
      for (int unsigned i = 0; i < NB; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cpu_register_file.sv
// Bench for cpu_register_file: directed vector table then randomized traffic
// against a byte-array reference model.
module tb_cpu_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, w8, w16, fw;
  logic [2:0]  s8, rd_a, rd_b;
  logic [7:0]  d8;
  logic [1:0]  p16, idop, idp, psel;
  logic [15:0] d16;
  logic [3:0]  fd;
  logic [7:0]  out_a, out_b;
  logic [15:0] out_pair;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

  cpu_register_file dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Enable    (en),
    .i_RdSelA    (rd_a),
    .o_RdDataA   (out_a),
    .i_RdSelB    (rd_b),
    .o_RdDataB   (out_b),
    .i_PairSel   (psel),
    .o_PairData  (out_pair),
    .i_Write8    (w8),
    .i_WrSel8    (s8),
    .i_WrData8   (d8),
    .i_Write16   (w16),
    .i_WrPair16  (p16),
    .i_WrData16  (d16),
    .i_IdOp      (idop),
    .i_IdPair    (idp),
    .i_FlagWrite (fw),
    .i_FlagData  (fd),
    .o_Flags     (out_flags)
  );

  typedef struct {
    logic        rst, en, w8;
    logic [2:0]  s8;
    logic [7:0]  d8;
    logic        w16;
    logic [1:0]  p16;
    logic [15:0] d16;
    logic [1:0]  idop, idp;
    logic        fw;
    logic [3:0]  fd;
    logic [15:0] bc, de, hl, af;
  } vec_t;

  localparam logic [63:0] InitVals = 64'h0013_00D8_014D_01B0;
  logic [7:0] m [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_b(input int b);
    logic [7:0] v;
    v = InitVals[(7-b)*8 +: 8];
    return (b == 7) ? (v & 8'hF0) : v;
  endfunction

  function automatic vec_t mk(input logic r, e, a8, input logic [2:0] s,
                              input logic [7:0] d, input logic a16, input logic [1:0] p,
                              input logic [15:0] dd, input logic [1:0] op, ip,
                              input logic f, input logic [3:0] fdat,
                              input logic [15:0] bc, de, hl, af);
    vec_t v;
    v.rst = r; v.en = e; v.w8 = a8; v.s8 = s; v.d8 = d; v.w16 = a16; v.p16 = p;
    v.d16 = dd; v.idop = op; v.idp = ip; v.fw = f; v.fd = fdat;
    v.bc = bc; v.de = de; v.hl = hl; v.af = af;
    return v;
  endfunction

  task automatic idle();
    rst = 0; en = 0; w8 = 0; w16 = 0; fw = 0; idop = 2'b00;
    s8 = 0; d8 = 0; p16 = 0; d16 = 0; idp = 0; fd = 0;
  endtask

  // Reference: each byte takes the highest-priority source aimed at it
  task automatic model_step();
    logic [7:0]  nm [8];
    logic [15:0] pv, idr;
    if (rst) begin
      for (int b = 0; b < 8; b++) m[b] = init_b(b);
    end else if (en) begin
      pv  = {m[2*idp], m[2*idp+1]};
      idr = (idop == 2'b01) ? pv + 16'd1 : pv - 16'd1;
      for (int b = 0; b < 8; b++) begin
        if (w16 && p16 == b / 2)                      nm[b] = (b % 2 == 0) ? d16[15:8] : d16[7:0];
        else if ((idop == 1 || idop == 2) && idp == b / 2) nm[b] = (b % 2 == 0) ? idr[15:8] : idr[7:0];
        else if (w8 && s8 == b)                       nm[b] = d8;
        else if (fw && b == 7)                        nm[b] = {fd, m[7][3:0]};
        else                                          nm[b] = m[b];
        if (b == 7) nm[b] = nm[b] & 8'hF0;
      end
      for (int b = 0; b < 8; b++) m[b] = nm[b];
    end
  endtask

  vec_t vecs [18];

  initial begin
    logic [15:0] exp_p [4];
    logic [7:0]  eb;

    vecs[0]  = mk(1,0,0,0,8'h00,0,0,16'h0000,0,0,0,0, 16'h0013,16'h00D8,16'h014D,16'h01B0);
    vecs[1]  = mk(0,1,1,6,8'h3C,0,0,16'h0000,0,0,0,0, 16'h0013,16'h00D8,16'h014D,16'h3CB0);
    vecs[2]  = mk(0,1,0,0,8'h00,1,3,16'h12FF,0,0,0,0, 16'h0013,16'h00D8,16'h014D,16'h12F0);
    vecs[3]  = mk(0,1,0,0,8'h00,1,2,16'hFFFF,0,0,0,0, 16'h0013,16'h00D8,16'hFFFF,16'h12F0);
    vecs[4]  = mk(0,1,0,0,8'h00,0,0,16'h0000,1,2,0,0, 16'h0013,16'h00D8,16'h0000,16'h12F0);
    vecs[5]  = mk(0,1,0,0,8'h00,1,0,16'h0000,0,0,0,0, 16'h0000,16'h00D8,16'h0000,16'h12F0);
    vecs[6]  = mk(0,1,0,0,8'h00,0,0,16'h0000,2,0,0,0, 16'hFFFF,16'h00D8,16'h0000,16'h12F0);
    vecs[7]  = mk(0,1,0,0,8'h00,1,1,16'h0100,0,0,0,0, 16'hFFFF,16'h0100,16'h0000,16'h12F0);
    vecs[8]  = mk(0,1,0,0,8'h00,0,0,16'h0000,2,1,0,0, 16'hFFFF,16'h00FF,16'h0000,16'h12F0);
    vecs[9]  = mk(0,1,1,3,8'h55,1,1,16'hAAAA,1,1,0,0, 16'hFFFF,16'hAAAA,16'h0000,16'h12F0);
    vecs[10] = mk(0,1,1,3,8'h55,0,0,16'h0000,1,1,0,0, 16'hFFFF,16'hAAAB,16'h0000,16'h12F0);
    vecs[11] = mk(0,1,1,7,8'h80,0,0,16'h0000,0,0,1,5, 16'hFFFF,16'hAAAB,16'h0000,16'h1280);
    vecs[12] = mk(0,1,1,0,8'h77,0,0,16'h0000,0,0,1,5, 16'h77FF,16'hAAAB,16'h0000,16'h1250);
    vecs[13] = mk(0,0,1,6,8'h00,1,2,16'h1234,1,0,1,15, 16'h77FF,16'hAAAB,16'h0000,16'h1250);
    vecs[14] = mk(1,1,0,0,8'h00,1,2,16'h1234,0,0,0,0, 16'h0013,16'h00D8,16'h014D,16'h01B0);
    vecs[15] = mk(0,1,0,0,8'h00,0,0,16'h0000,2,3,0,0, 16'h0013,16'h00D8,16'h014D,16'h01A0);
    vecs[16] = mk(0,1,1,6,8'h99,1,0,16'hBEEF,0,0,0,0, 16'hBEEF,16'h00D8,16'h014D,16'h99A0);
    vecs[17] = mk(0,1,0,0,8'h00,0,0,16'h0000,3,2,0,0, 16'hBEEF,16'h00D8,16'h014D,16'h99A0);

    idle();
    rd_a = 0; rd_b = 0; psel = 0;
    @(posedge clk); #1;

    for (int v = 0; v < 18; v++) begin
      rst = vecs[v].rst; en = vecs[v].en; w8 = vecs[v].w8; s8 = vecs[v].s8;
      d8 = vecs[v].d8; w16 = vecs[v].w16; p16 = vecs[v].p16; d16 = vecs[v].d16;
      idop = vecs[v].idop; idp = vecs[v].idp; fw = vecs[v].fw; fd = vecs[v].fd;
      @(posedge clk); #1;
      idle();
      exp_p[0] = vecs[v].bc; exp_p[1] = vecs[v].de;
      exp_p[2] = vecs[v].hl; exp_p[3] = vecs[v].af;
      for (int p = 0; p < 4; p++) begin
        psel = 2'(p); #1;
        chk($sformatf("vec%0d pair%0d", v, p), 32'(out_pair), 32'(exp_p[p]));
      end
      for (int b = 0; b < 8; b++) begin
        rd_a = 3'(b); rd_b = 3'(7 - b); #1;
        eb = (b % 2 == 0) ? exp_p[b/2][15:8] : exp_p[b/2][7:0];
        chk($sformatf("vec%0d portA byte%0d", v, b), 32'(out_a), 32'(eb));
        eb = ((7 - b) % 2 == 0) ? exp_p[(7-b)/2][15:8] : exp_p[(7-b)/2][7:0];
        chk($sformatf("vec%0d portB byte%0d", v, 7 - b), 32'(out_b), 32'(eb));
      end
      chk($sformatf("vec%0d flags", v), 32'(out_flags), 32'(vecs[v].af[7:4]));
    end

    // Randomized traffic against the reference model
    rst = 1; en = 0;
    model_step();
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 49) == 0);
      en   = ($urandom_range(0, 7) != 0);
      w8   = $urandom_range(0, 1) == 1;
      s8   = 3'($urandom_range(0, 7));
      d8   = 8'($urandom);
      w16  = $urandom_range(0, 2) == 0;
      p16  = 2'($urandom_range(0, 3));
      d16  = 16'($urandom);
      idop = 2'($urandom_range(0, 3));
      idp  = 2'($urandom_range(0, 3));
      fw   = $urandom_range(0, 1) == 1;
      fd   = 4'($urandom);
      rd_a = 3'($urandom_range(0, 7));
      rd_b = 3'($urandom_range(0, 7));
      psel = 2'($urandom_range(0, 3));
      model_step();
      @(posedge clk); #1;
      chk($sformatf("rnd%0d portA sel%0d", n, rd_a), 32'(out_a), 32'(m[rd_a]));
      chk($sformatf("rnd%0d portB sel%0d", n, rd_b), 32'(out_b), 32'(m[rd_b]));
      chk($sformatf("rnd%0d pair%0d", n, psel), 32'(out_pair),
          32'({m[2*psel], m[2*psel+1]}));
      chk($sformatf("rnd%0d flags", n), 32'(out_flags), 32'(m[7][7:4]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_register_file.md
Name: cpu_register_file

Overview:
- Parametrised SM83-style register file that replaces the discrete per-register instances in the CPU datapath.
- Holds NUM_PAIRS pairs of REG_WIDTH-bit registers: byte index 2k is the high half of pair k, index 2k+1 is the low half.
- Provides two byte read ports, one pair read port, byte and pair writes, a pair increment/decrement unit and a flag-nibble write into the flag register.
- Sits between the CPU control FSM/ALU and the address/data buses.

Parameters:
- REG_WIDTH, 8, width of one register (must be >= 4).
- NUM_PAIRS, 4, number of register pairs; defaults are pair 0=BC, 1=DE, 2=HL, 3=AF.
- FLAG_IDX, 7, byte index of the flag register (F).
- FLAG_MASK, 8'hF0, bits of F that are writable; masked bits always read 0. Width is REG_WIDTH.
- INIT_VALUES, {8'h00,8'h13,8'h00,8'hD8,8'h01,8'h4D,8'h01,8'hB0}, packed reset values. Index 0 is the MSB slice; width is 2*NUM_PAIRS*REG_WIDTH.
- Derived widths: SW = $clog2(2*NUM_PAIRS) and PW = $clog2(NUM_PAIRS).

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Enable  in  1  tick enable; when low, all updates except reset are ignored.
- i_RdSelA  in  SW  byte read select, port A.
- o_RdDataA  out  REG_WIDTH  byte read data, port A.
- i_RdSelB  in  SW  byte read select, port B.
- o_RdDataB  out  REG_WIDTH  byte read data, port B.
- i_PairSel  in  PW  pair read select.
- o_PairData  out  2*REG_WIDTH  pair read data, {hi,lo}.
- i_Write8  in  1  byte write strobe.
- i_WrSel8  in  SW  byte write target.
- i_WrData8  in  REG_WIDTH  byte write data.
- i_Write16  in  1  pair write strobe.
- i_WrPair16  in  PW  pair write target.
- i_WrData16  in  2*REG_WIDTH  pair write data.
- i_IdOp  in  2  increment/decrement op: 00 none, 01 increment, 10 decrement, 11 none.
- i_IdPair  in  PW  increment/decrement target pair.
- i_FlagWrite  in  1  flag nibble write strobe.
- i_FlagData  in  4  {Z,N,H,C}, written to F[REG_WIDTH-1:REG_WIDTH-4].
- o_Flags  out  4  current F[REG_WIDTH-1:REG_WIDTH-4].

Behaviour:
- Reset and enable:
  - On a rising i_Clk edge with i_Reset=1, every byte loads its INIT_VALUES slice ANDed with FLAG_MASK for FLAG_IDX. This happens regardless of i_Enable.
  - With the defaults, after reset: AF=01B0, BC=0013, DE=00D8, HL=014D, o_Flags=4'hB.
  - When i_Reset=0 and i_Enable=0, state holds.
- Reads:
  - All reads are combinational from the current state. There is no write-through bypass.
  - A value written at edge N is visible after edge N.
  - All outputs follow from the state, so their reset values are the reset state above.
- Per-byte update on an enabled edge: each byte independently takes the highest-priority source that targets it, else holds.
  - Priority: pair write > increment/decrement > byte write > flag write.
  - Sources targeting different bytes all commit in the same cycle. Example: a pair write to BC together with a byte write to A commits both.
  - Flag write and byte write both hitting F: the byte write wins for the whole byte.
- Increment/decrement:
  - Operates on the full 2*REG_WIDTH pair value and wraps modulo 2^(2*REG_WIDTH): FFFF+1=0000, 0000-1=FFFF.
  - A carry or borrow between halves is internal only; no flags are affected.
  - Increment/decrement on the AF pair is legal; the result is masked like any F write.
- F masking: every path that writes F (pair, increment/decrement, byte) applies FLAG_MASK. Masked bits are never stored as 1.
- Out-of-range selects (index >= 2*NUM_PAIRS when not a power of two): writes are ignored and reads return 0.
- A reset asserted mid-sequence discards any update in the same cycle; reset wins.

Decomposition:
- Shared package (cpu_pkg):
  - byte index constants: REG_B..REG_A, REG_F
  - pair constants: PAIR_BC, PAIR_DE, PAIR_HL, PAIR_AF
  - IDOP_NONE, IDOP_INC, IDOP_DEC encodings
  - flag bit positions: FLAG_Z, FLAG_N, FLAG_H, FLAG_C
- One natural combinational sub-module, pair_inc_dec, parametrised by width. It is reused later by the SP/PC unit.

Test Plan:
- Reset: assert i_Reset for 1 cycle with i_Enable=0 -> o_PairData = 01B0/0013/00D8/014D for AF/BC/DE/HL; o_Flags=B.
- Byte write A=3C, then a pair write AF=12FF -> A=12 and F=F0 (low nibble masked); read port B on REG_F = F0 in the same cycle that port A shows A.
- Increment HL=FFFF -> 0000; decrement BC=0000 -> FFFF; decrement DE=0100 -> 00FF. Flags are unchanged in every case.
- Same cycle: pair write DE=AAAA, increment DE, byte write E=55 -> DE=AAAA. Next cycle: increment DE plus byte write E=55 -> DE=AAAB.
- Same cycle: flag write 4'h5 and byte write F=80 -> F=80. Next cycle: flag write 4'h5 plus byte write B=77 -> F=50 and B=77.
- With i_Enable=0, drive all strobes -> no state change. Then i_Reset=1 together with i_Write16 and i_Enable=1 -> reset values load and the write is dropped.
